frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Sequences the 4-channel sample datapath from the SPI word stream. Consumes 14-bit words from the SPI receiver, locks onto the 0x0FFF header word, and steers the next four words to channel sample registers 0..3 with one-hot write strobes. Asserts a one-cycle start pulse to the delay/processing stage when a complete frame has landed. Detects inter-word timeouts and processing overruns.

## Interface
- `DW`, 14: sample/word width
- `NCH`, 4: channels per frame
- `HEADER`, 14'h0FFF: frame header word
- `TIMEOUT_CYC`, 1024: max idle clk cycles between in-frame words (100 MHz clk)
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous, active-low reset
- `en`  in  1  sequencer enable; low forces HUNT at next edge
- `word_valid`  in  1  one-cycle pulse: `word_data` holds a complete SPI word
- `word_data`  in  DW  received word, MSB first as shifted
- `proc_busy`  in  1  processing stage still working on previous frame
- `ch_wr`  out  NCH  one-hot channel write strobe, one cycle
- `ch_data`  out  DW  sample for `ch_wr`, valid only while `ch_wr` != 0
- `head_flag`  out  1  one-cycle processing start pulse (frame complete)
- `frame_err`  out  1  one-cycle error pulse
- `err_code`  out  2  last error: 00 none, 01 timeout, 10 overrun
- `frame_cnt`  out  16  completed-frame counter

## Operation
- Reset: state HUNT, `ch_wr`=0, `ch_data`=0, `head_flag`=0, `frame_err`=0, `err_code`=00, `frame_cnt`=0, channel index=0, gap timer=0.
- HUNT: `word_valid` with `word_data`==HEADER -> COLLECT, index=0, timer cleared. Any other word ignored.
- COLLECT: on `word_valid`, register `ch_data`=word, `ch_wr`=1<<index, timer cleared, index+1. Header value inside COLLECT is sample data (positional framing, 0x0FFF = +4095).
- Last word (index==NCH-1): write issued as normal; then if `proc_busy`=0 -> `head_flag` pulse, `frame_cnt`+1, `err_code`=00; if `proc_busy`=1 -> `frame_err` pulse, `err_code`=10, no `head_flag`, no count. Either way -> HUNT.
- Gap timer counts clk cycles in COLLECT without `word_valid`; reaching TIMEOUT_CYC -> `frame_err` pulse, `err_code`=01, -> HUNT. Partial writes already issued are not retracted.
- `en`=0: any state -> HUNT next edge, no pulses generated; `frame_cnt`/`err_code` retained.
- `frame_cnt` wraps 0xFFFF -> 0x0000.
- `err_code` holds until next error or next good frame.

## Timing
- All outputs registered. `ch_wr`/`ch_data` appear 1 cycle after the `word_valid` edge.
- `head_flag` / overrun `frame_err` coincide with the last `ch_wr` (same cycle); `frame_cnt` updates that cycle.
- `proc_busy` sampled in the `word_valid` cycle of the last word.
- Timeout `frame_err` asserts on the cycle the timer reaches TIMEOUT_CYC (counted from the last accepted word or header).
- `word_valid` in the same cycle the timer reaches TIMEOUT_CYC: word accepted, no timeout.
- Back-to-back `word_valid` (consecutive cycles) supported, one word per cycle, no stall.
- Header arriving in the cycle after last-word completion is accepted (HUNT reached without a bubble).
- Async `rstn` low mid-frame: all outputs clear immediately, no pulse emitted; resume in HUNT after release.

## Structure
- Package `frame_seq_pkg`: DW, NCH, HEADER, state enum (HUNT, COLLECT), err code constants (ERR_NONE, ERR_TIMEOUT, ERR_OVERRUN).
- Sub-module `gap_timer`: clear/enable inputs, saturating counter, `expired` output at TIMEOUT_CYC.

## Test plan
- Frame 0x0FFF, 100, 200, 300, 400 (SPI timing: 260 cycles/word) -> ch_wr 0001/0010/0100/1000 with data 100..400, one `head_flag`, `frame_cnt`=1, `err_code`=00.
- Words 5, 0x0FFF, 1, 2, 3, 0x0FFF -> leading 5 ignored; samples 1, 2, 3, 4095 to ch0..3; `head_flag` once.
- Header + 2 samples, then 1024 idle cycles -> `frame_err` at cycle 1024 after 2nd sample, `err_code`=01, no `head_flag`; next full frame completes normally, `err_code`=00.
- Full frame with `proc_busy`=1 at last word -> all 4 writes issued, `frame_err` pulse, `err_code`=10, `frame_cnt` unchanged.
- `frame_cnt` preloaded to 0xFFFF by 65535 frames (or forced) + one frame -> 0x0000.
- `rstn` low after 2nd sample -> outputs zero immediately; after release, frame 0x0FFF, 7, 8, 9, 10 -> normal completion, `frame_cnt`=1.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// frame_seq_pkg: shared widths, header word, FSM states and error codes for the frame sequencer
package frame_seq_pkg;
   localparam int DW = 14;
   localparam int NCH = 4;
   localparam int IW = $clog2(NCH);
   localparam logic [DW-1:0] HEADER = 14'h0FFF;
   localparam int TIMEOUT_CYC = 1024;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic {HUNT, COLLECT} state_t;
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_OVERRUN = 2'b10;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: word stream in, channel strobes/status out of the frame sequencer
interface frame_sequencer_if;
   import frame_seq_pkg::*;
   logic en;
   logic word_valid;
   logic [DW-1:0] word_data;
   logic proc_busy;
   logic [NCH-1:0] ch_wr;
   logic [DW-1:0] ch_data;
   logic head_flag;
   logic frame_err;
   logic [1:0] err_code;
   logic [15:0] frame_cnt;
   modport master (
      output en, word_valid, word_data, proc_busy,
      input ch_wr, ch_data, head_flag, frame_err, err_code, frame_cnt
   );
   modport slave (
      input en, word_valid, word_data, proc_busy,
      output ch_wr, ch_data, head_flag, frame_err, err_code, frame_cnt
   );
endinterface

// File: rtl/gap_timer.sv
// gap_timer: saturating idle-cycle counter; expired marks the idle cycle that reaches TIMEOUT_CYC
module gap_timer import frame_seq_pkg::*; (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);
   logic [TW-1:0] cnt;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && cnt != LIMIT) cnt <= cnt + 1'b1;
   assign expired = enable && cnt >= LIMIT - 1'b1;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: locks onto the header word and steers the following NCH words to channel strobes
module frame_sequencer import frame_seq_pkg::*; (
   input logic clk,
   input logic rstn,
   frame_sequencer_if.slave bus
);
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);
   state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [NCH-1:0] wr_q, wr_n;
   logic [DW-1:0] data_q, data_n;
   logic head_q, head_n, err_q, err_n;
   logic [1:0] code_q, code_n;
   logic [15:0] cnt_q, cnt_n;
   logic collect, expired;
   assign collect = state == COLLECT && bus.en;
   gap_timer u_timer (
      .clk(clk),
      .rstn(rstn),
      .clear(!collect || bus.word_valid),
      .enable(collect && !bus.word_valid),
      .expired(expired)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= HUNT;
         idx <= '0;
         wr_q <= '0;
         data_q <= '0;
         head_q <= 1'b0;
         err_q <= 1'b0;
         code_q <= ERR_NONE;
         cnt_q <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         wr_q <= wr_n;
         data_q <= data_n;
         head_q <= head_n;
         err_q <= err_n;
         code_q <= code_n;
         cnt_q <= cnt_n;
      end
   always_comb begin
      state_n = state;
      idx_n = idx;
      wr_n = '0;
      data_n = data_q;
      head_n = 1'b0;
      err_n = 1'b0;
      code_n = code_q;
      cnt_n = cnt_q;
      if (!bus.en) begin
         state_n = HUNT;
         idx_n = '0;
      end else if (state == HUNT) begin
         if (bus.word_valid && bus.word_data == HEADER) begin
            state_n = COLLECT;
            idx_n = '0;
         end
      end else if (bus.word_valid) begin
         wr_n = NCH'(1) << idx;
         data_n = bus.word_data;
         idx_n = idx + 1'b1;
         if (idx == LAST) begin
            // frame complete: busy downstream turns the start pulse into an overrun
            state_n = HUNT;
            idx_n = '0;
            head_n = !bus.proc_busy;
            err_n = bus.proc_busy;
            code_n = bus.proc_busy ? ERR_OVERRUN : ERR_NONE;
            cnt_n = bus.proc_busy ? cnt_q : cnt_q + 16'd1;
         end
      end else if (expired) begin
         state_n = HUNT;
         err_n = 1'b1;
         code_n = ERR_TIMEOUT;
      end
   end
   assign bus.ch_wr = wr_q;
   assign bus.ch_data = data_q;
   assign bus.head_flag = head_q;
   assign bus.frame_err = err_q;
   assign bus.err_code = code_q;
   assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed literal checks plus randomized word stream against a positional frame model
module tb_frame_sequencer;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int total = 0;
   int bad = 0;
   frame_sequencer_if bus();
   frame_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;

   int pos = -1;
   int idle = 0;
   bit [3:0] m_wr;
   bit [13:0] m_data;
   bit m_head, m_err;
   bit [1:0] m_code;
   bit [15:0] m_cnt;

   // model: pos = samples taken in the current frame (-1 while hunting), idle = cycles since last accepted word
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pos = -1; idle = 0; m_wr = 0; m_data = 0; m_head = 0; m_err = 0; m_code = 0; m_cnt = 0;
      end else begin
         m_wr = 0; m_head = 0; m_err = 0;
         if (!bus.en) pos = -1;
         else if (pos < 0) begin
            if (bus.word_valid && bus.word_data == 14'h0FFF) begin pos = 0; idle = 0; end
         end else if (bus.word_valid) begin
            m_wr = 4'(1 << pos); m_data = bus.word_data; idle = 0; pos++;
            if (pos == 4) begin
               pos = -1;
               if (bus.proc_busy) begin m_err = 1; m_code = 2; end
               else begin m_head = 1; m_cnt++; m_code = 0; end
            end
         end else begin
            idle++;
            if (idle == 1024) begin m_err = 1; m_code = 1; pos = -1; end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("ch_wr", 32'(bus.ch_wr), 32'(m_wr));
      if (m_wr != 0) check("ch_data", 32'(bus.ch_data), 32'(m_data));
      check("head_flag", 32'(bus.head_flag), 32'(m_head));
      check("frame_err", 32'(bus.frame_err), 32'(m_err));
      check("err_code", 32'(bus.err_code), 32'(m_code));
      check("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [13:0] w, input logic b = 1'b0);
      bus.word_valid = 1'b1; bus.word_data = w; bus.proc_busy = b;
      tick;
      bus.word_valid = 1'b0; bus.proc_busy = 1'b0;
   endtask

   task automatic frame(input logic [13:0] a, input logic [13:0] b, input logic [13:0] c, input logic [13:0] d);
      send(14'h0FFF); send(a); send(b); send(c); send(d);
   endtask

   initial begin
      int r, gap;
      bus.en = 1'b1; bus.word_valid = 1'b0; bus.word_data = '0; bus.proc_busy = 1'b0;
      repeat (3) tick;
      check("rst ch_wr", 32'(bus.ch_wr), 0);
      check("rst ch_data", 32'(bus.ch_data), 0);
      check("rst head", 32'(bus.head_flag), 0);
      check("rst err", 32'(bus.frame_err), 0);
      check("rst code", 32'(bus.err_code), 0);
      check("rst cnt", 32'(bus.frame_cnt), 0);
      rstn = 1'b1;
      tick;
      // SPI-paced frame
      send(14'h0FFF); repeat (259) tick;
      send(14'd100); check("spi w0", 32'(bus.ch_wr), 1); check("spi d0", 32'(bus.ch_data), 100); repeat (259) tick;
      send(14'd200); check("spi w1", 32'(bus.ch_wr), 2); check("spi d1", 32'(bus.ch_data), 200); repeat (259) tick;
      send(14'd300); check("spi w2", 32'(bus.ch_wr), 4); check("spi d2", 32'(bus.ch_data), 300); repeat (259) tick;
      send(14'd400); check("spi w3", 32'(bus.ch_wr), 8); check("spi d3", 32'(bus.ch_data), 400);
      check("spi head", 32'(bus.head_flag), 1); check("spi cnt", 32'(bus.frame_cnt), 1); check("spi code", 32'(bus.err_code), 0);
      tick;
      // leading junk ignored, in-frame header value is data
      send(14'd5); check("junk", 32'(bus.ch_wr), 0);
      send(14'h0FFF); send(14'd1); check("b2b w0", 32'(bus.ch_wr), 1);
      send(14'd2); send(14'd3);
      send(14'h0FFF); check("b2b w3", 32'(bus.ch_wr), 8); check("b2b d3", 32'(bus.ch_data), 32'h0FFF);
      check("b2b head", 32'(bus.head_flag), 1); check("b2b cnt", 32'(bus.frame_cnt), 2);
      // timeout after two samples
      send(14'h0FFF); send(14'd1); send(14'd2);
      repeat (1023) tick;
      check("to early", 32'(bus.frame_err), 0);
      tick;
      check("to err", 32'(bus.frame_err), 1); check("to code", 32'(bus.err_code), 1); check("to head", 32'(bus.head_flag), 0);
      frame(14'd10, 14'd20, 14'd30, 14'd40);
      check("after to head", 32'(bus.head_flag), 1); check("after to code", 32'(bus.err_code), 0); check("after to cnt", 32'(bus.frame_cnt), 3);
      // word arriving exactly at the limit is accepted
      send(14'h0FFF); repeat (1023) tick;
      send(14'd11); check("edge wr", 32'(bus.ch_wr), 1); check("edge err", 32'(bus.frame_err), 0);
      send(14'd12); send(14'd13); send(14'd14); check("edge cnt", 32'(bus.frame_cnt), 4);
      // overrun
      send(14'h0FFF); send(14'd1); send(14'd2); send(14'd3); send(14'd4, 1'b1);
      check("ovr wr", 32'(bus.ch_wr), 8); check("ovr err", 32'(bus.frame_err), 1); check("ovr head", 32'(bus.head_flag), 0);
      check("ovr code", 32'(bus.err_code), 2); check("ovr cnt", 32'(bus.frame_cnt), 4);
      // async reset mid-frame
      send(14'h0FFF); send(14'd1); send(14'd2);
      #2 rstn = 1'b0;
      #1;
      check("arst wr", 32'(bus.ch_wr), 0); check("arst data", 32'(bus.ch_data), 0);
      check("arst code", 32'(bus.err_code), 0); check("arst cnt", 32'(bus.frame_cnt), 0);
      tick; tick;
      rstn = 1'b1;
      tick;
      frame(14'd7, 14'd8, 14'd9, 14'd10);
      check("post rst head", 32'(bus.head_flag), 1); check("post rst data", 32'(bus.ch_data), 10); check("post rst cnt", 32'(bus.frame_cnt), 1);
      // counter wrap
      tick;
      force dut.cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      tick;
      release dut.cnt_q;
      tick;
      check("preload cnt", 32'(bus.frame_cnt), 32'hFFFF);
      frame(14'd1, 14'd2, 14'd3, 14'd4);
      check("wrap cnt", 32'(bus.frame_cnt), 0); check("wrap head", 32'(bus.head_flag), 1);
      // randomized word stream
      for (int i = 0; i < 1200; i++) begin
         r = $urandom_range(0, 99);
         gap = r < 65 ? 0 : r < 92 ? $urandom_range(1, 6) : r < 98 ? $urandom_range(20, 300) : $urandom_range(1020, 1027);
         repeat (gap) begin
            bus.en = $urandom_range(0, 199) != 0;
            tick;
         end
         bus.en = $urandom_range(0, 99) != 0;
         send($urandom_range(0, 99) < 35 ? 14'h0FFF : 14'($urandom), $urandom_range(0, 3) == 0);
      end
      bus.en = 1'b1;
      repeat (5) tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
